// File: rtl/float32_mul_arb_pkg.sv
// Shared types for the float32 multiplier arbiter: FSM state, in-flight tag, data width.
package float32_mul_arb_pkg;

    localparam int FLOAT_W = 32;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

endpackage

// File: rtl/float32_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o
);

    logic found_s;

    // Two passes give wrap-around priority: indices above the pointer first, then the rest.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req_i[i] && (i > int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_s && req_i[i] && (i <= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/float32_mul_arbiter.sv
// Shares one fixed-latency float32 multiplier among N_REQ requesters with round-robin grants.
// Optional FLOAT32_MUL_ARB_STATS_EN adds per-requester saturating grant counters.
module float32_mul_arbiter
    import float32_mul_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 6
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_enable,
    input  logic [N_REQ-1:0]           in_req_valid,
    input  logic [N_REQ*FLOAT_W-1:0]   in_req_A,
    input  logic [N_REQ*FLOAT_W-1:0]   in_req_B,
    output logic [N_REQ-1:0]           out_req_ready,
    output logic [FLOAT_W-1:0]         out_mul_A,
    output logic [FLOAT_W-1:0]         out_mul_B,
    output logic                       out_mul_valid,
    input  logic [FLOAT_W-1:0]         in_mul_result,
    output logic [N_REQ-1:0]           out_resp_valid,
    output logic [FLOAT_W-1:0]         out_resp_data,
`ifdef FLOAT32_MUL_ARB_STATS_EN
    output logic [N_REQ*FLOAT_W-1:0]   out_grant_count,
`endif
    output logic                       out_idle
);

    localparam int PW = $clog2(N_REQ);

    state_e               state_q, state_d;
    logic                 idle_q;
    logic [PW-1:0]        last_grant_q;
    logic [N_REQ-1:0]     arb_grant_s, grant_s;
    logic [PW-1:0]        grant_idx_s;
    logic                 grant_any_s;
    logic [FLOAT_W-1:0]   sel_a_s, sel_b_s;
    logic [FLOAT_W-1:0]   mul_a_q, mul_b_q;
    tag_t                 issue_tag_q;
    tag_t                 tag_q [MUL_LATENCY];
    tag_t                 exit_tag_s;
    logic                 busy_now_s, busy_next_s;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (in_req_valid),
        .ptr_i   (last_grant_q),
        .grant_o (arb_grant_s)
    );

    // Grant gating, index encode and operand select for the granted requester.
    always_comb begin
        grant_s     = ((state_q == RUN) && in_enable) ? arb_grant_s : '0;
        grant_any_s = |grant_s;
        grant_idx_s = '0;
        sel_a_s     = '0;
        sel_b_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                grant_idx_s = PW'(i);
                sel_a_s     = in_req_A[i*FLOAT_W +: FLOAT_W];
                sel_b_s     = in_req_B[i*FLOAT_W +: FLOAT_W];
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // busy_next predicts emptiness one cycle ahead so out_idle can be a register.
    always_comb begin
        busy_now_s  = issue_tag_q.valid;
        busy_next_s = grant_any_s | issue_tag_q.valid;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            busy_now_s = busy_now_s | tag_q[k].valid;
        end
        for (int k = 0; k < MUL_LATENCY - 1; k++) begin
            busy_next_s = busy_next_s | tag_q[k].valid;
        end
    end

    // Next-state logic for the IDLE/RUN/DRAIN controller.
    always_comb begin
        case (state_q)
            IDLE:    state_d = in_enable ? RUN : IDLE;
            RUN:     state_d = in_enable ? RUN : DRAIN;
            DRAIN: begin
                if (in_enable) begin
                    state_d = RUN;
                end else if (!busy_now_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, registered idle flag and round-robin pointer.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= IDLE;
            idle_q       <= 1'b1;
            last_grant_q <= PW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d != RUN) && !busy_next_s;
            if (grant_any_s) begin
                last_grant_q <= grant_idx_s;
            end
        end
    end

    // Issue register and tag pipeline; the tag leaves exactly when the product arrives.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_tag_q <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (grant_any_s) begin
                mul_a_q <= sel_a_s;
                mul_b_q <= sel_b_s;
            end
            issue_tag_q.valid <= grant_any_s;
            issue_tag_q.index <= IDX_W'(grant_idx_s);
            tag_q[0]          <= issue_tag_q;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Response strobe decode from the exiting tag.
    always_comb begin
        exit_tag_s     = tag_q[MUL_LATENCY-1];
        out_resp_valid = '0;
        if (exit_tag_s.valid) begin
            out_resp_data = in_mul_result;
            for (int i = 0; i < N_REQ; i++) begin
                out_resp_valid[i] = (exit_tag_s.index == IDX_W'(i));
            end
        end else begin
            out_resp_data = '0;
        end
    end

    assign out_req_ready = grant_s;
    assign out_mul_A     = mul_a_q;
    assign out_mul_B     = mul_b_q;
    assign out_mul_valid = issue_tag_q.valid;
    assign out_idle      = idle_q;

`ifdef FLOAT32_MUL_ARB_STATS_EN
    logic [FLOAT_W-1:0] gcnt_q [N_REQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_s[i] && (gcnt_q[i] != 32'hFFFF_FFFF)) begin
                    gcnt_q[i] <= gcnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Pack counters like the operand buses.
    always_comb begin
        out_grant_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            out_grant_count[i*FLOAT_W +: FLOAT_W] = gcnt_q[i];
        end
    end
`endif

endmodule
